symbol_draw_arbiter: RTL and testbench

- Shares the single VGA plot port between N_REQ sprite-drawing requesters (player, enemies, cursor, etc.).
- Grants one requester at a time, round-robin. Walks a SYM_W x SYM_H bounding box at the latched origin.
- Queries an external symbol mask ROM per pixel and emits one pixel per clock to the VGA adapter.
- Supports draw (mask-gated, requester colour) and erase (whole box, background colour).

---
 rtl/symbol_draw_arbiter_pkg.sv | 20 ++
 rtl/symbol_draw_arbiter_if.sv | 42 ++++
 rtl/symbol_draw_arbiter_rr_pick_n.sv | 26 ++
 rtl/symbol_draw_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_symbol_draw_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/symbol_draw_arbiter_pkg.sv
// rtl/symbol_draw_arbiter_pkg.sv - shared types and constants for the symbol draw arbiter
package symbol_draw_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COL_W    = 3;
    localparam int SYM_ID_W = 2;

    localparam logic [COL_W-1:0] BG_COLOUR_DEFAULT = 3'b000;

endpackage

// File: rtl/symbol_draw_arbiter_if.sv
// rtl/symbol_draw_arbiter_if.sv - requester, mask ROM and VGA plot signals of the arbiter
interface symbol_draw_arbiter_if
    import symbol_draw_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int SYM_W = 16,
    parameter int SYM_H = 16
);
    localparam int DX_W = $clog2(SYM_W);
    localparam int DY_W = $clog2(SYM_H);

    logic [N_REQ-1:0]          req;
    logic [N_REQ-1:0]          erase;
    logic [X_W*N_REQ-1:0]      req_x;
    logic [Y_W*N_REQ-1:0]      req_y;
    logic [SYM_ID_W*N_REQ-1:0] req_sym;
    logic [COL_W*N_REQ-1:0]    req_colour;
    logic [N_REQ-1:0]          grant;
    logic [N_REQ-1:0]          done;
    logic                      busy;
    logic [SYM_ID_W-1:0]       rom_sym;
    logic [DX_W-1:0]           rom_dx;
    logic [DY_W-1:0]           rom_dy;
    logic                      rom_bit;
    logic                      plot;
    logic [X_W-1:0]            vga_x;
    logic [Y_W-1:0]            vga_y;
    logic [COL_W-1:0]          vga_colour;

    modport master (
        input  req, erase, req_x, req_y, req_sym, req_colour, rom_bit,
        output grant, done, busy, rom_sym, rom_dx, rom_dy,
               plot, vga_x, vga_y, vga_colour
    );

    modport slave (
        output req, erase, req_x, req_y, req_sym, req_colour, rom_bit,
        input  grant, done, busy, rom_sym, rom_dx, rom_dy,
               plot, vga_x, vga_y, vga_colour
    );

endinterface

// File: rtl/symbol_draw_arbiter_rr_pick_n.sv
// rtl/symbol_draw_arbiter_rr_pick_n.sv - combinational round-robin pick starting after last_idx
module rr_pick_n #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [N-1:0]     pick,
    output logic             valid
);

    always_comb begin
        int idx;
        idx   = 0;
        pick  = '0;
        valid = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_idx) + k) % N;
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/symbol_draw_arbiter.sv
// rtl/symbol_draw_arbiter.sv - round-robin arbiter walking a symbol box onto the VGA plot port
module symbol_draw_arbiter
    import symbol_draw_arbiter_pkg::*;
#(
    parameter int               N_REQ     = 4,
    parameter int               SYM_W     = 16,
    parameter int               SYM_H     = 16,
    parameter logic [COL_W-1:0] BG_COLOUR = BG_COLOUR_DEFAULT
) (
    input logic                  clk,
    input logic                  reset_n,
    symbol_draw_arbiter_if.master bus
);

    localparam int DX_W  = $clog2(SYM_W);
    localparam int DY_W  = $clog2(SYM_H);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [DX_W-1:0] DX_MAX = DX_W'(SYM_W - 1);
    localparam logic [DY_W-1:0] DY_MAX = DY_W'(SYM_H - 1);

    state_t               state_q, state_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [DX_W-1:0]      dx_q, dx_d;
    logic [DY_W-1:0]      dy_q, dy_d;
    logic [X_W-1:0]       x_q, x_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic [SYM_ID_W-1:0]  sym_q, sym_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic                 er_q, er_d;
    logic                 plot_q, plot_d;
    logic [X_W-1:0]       vga_x_q, vga_x_d;
    logic [Y_W-1:0]       vga_y_q, vga_y_d;
    logic [COL_W-1:0]     vga_col_q, vga_col_d;

    logic [N_REQ-1:0]     pick;
    logic                 pick_valid;
    logic [IDX_W-1:0]     sel_idx;
    logic [X_W-1:0]       sel_x;
    logic [Y_W-1:0]       sel_y;
    logic [SYM_ID_W-1:0]  sel_sym;
    logic [COL_W-1:0]     sel_col;
    logic                 sel_er;
    logic [X_W:0]         sx;
    logic [Y_W:0]         sy;
    logic                 on_screen;
    logic [N_REQ-1:0]     done_o;
    logic                 busy_o;

    rr_pick_n #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req      (bus.req),
        .last_idx (last_q),
        .pick     (pick),
        .valid    (pick_valid)
    );

    always_comb begin
        sel_idx = '0;
        sel_x   = '0;
        sel_y   = '0;
        sel_sym = '0;
        sel_col = '0;
        sel_er  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) begin
                sel_idx = IDX_W'(i);
                sel_x   = bus.req_x[X_W*i +: X_W];
                sel_y   = bus.req_y[Y_W*i +: Y_W];
                sel_sym = bus.req_sym[SYM_ID_W*i +: SYM_ID_W];
                sel_col = bus.req_colour[COL_W*i +: COL_W];
                sel_er  = bus.erase[i];
            end
        end
    end

    // Sums are one bit wider than the screen coordinate so off-screen pixels clip rather than wrap.
    assign sx        = {1'b0, x_q} + (X_W+1)'(dx_q);
    assign sy        = {1'b0, y_q} + (Y_W+1)'(dy_q);
    assign on_screen = (sx < (X_W+1)'(SCREEN_W)) && (sy < (Y_W+1)'(SCREEN_H));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_valid) state_d = ST_WALK;
            ST_WALK: if (dx_q == DX_MAX && dy_q == DY_MAX) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        done_o = (state_q == ST_DONE) ? grant_q : '0;
        busy_o = (state_q != ST_IDLE);
    end

    always_comb begin
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        last_d    = last_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        x_d       = x_q;
        y_d       = y_q;
        sym_d     = sym_q;
        col_d     = col_q;
        er_d      = er_q;
        plot_d    = 1'b0;
        vga_x_d   = vga_x_q;
        vga_y_d   = vga_y_q;
        vga_col_d = vga_col_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick;
                    gidx_d  = sel_idx;
                    x_d     = sel_x;
                    y_d     = sel_y;
                    sym_d   = sel_sym;
                    col_d   = sel_col;
                    er_d    = sel_er;
                    dx_d    = '0;
                    dy_d    = '0;
                end
            end
            ST_WALK: begin
                dx_d = dx_q + DX_W'(1);
                if (dx_q == DX_MAX) dy_d = dy_q + DY_W'(1);
                plot_d    = (er_q | bus.rom_bit) & on_screen;
                vga_x_d   = sx[X_W-1:0];
                vga_y_d   = sy[Y_W-1:0];
                vga_col_d = er_q ? BG_COLOUR : col_q;
            end
            ST_DONE: begin
                grant_d = '0;
                last_d  = gidx_q;
            end
            default: begin
                grant_d = '0;
            end
        endcase
    end

    // Pointer resets to the last index so requester 0 is searched first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q   <= '0;
            gidx_q    <= '0;
            last_q    <= IDX_W'(N_REQ - 1);
            dx_q      <= '0;
            dy_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            sym_q     <= '0;
            col_q     <= '0;
            er_q      <= 1'b0;
            plot_q    <= 1'b0;
            vga_x_q   <= '0;
            vga_y_q   <= '0;
            vga_col_q <= '0;
        end else begin
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            last_q    <= last_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            x_q       <= x_d;
            y_q       <= y_d;
            sym_q     <= sym_d;
            col_q     <= col_d;
            er_q      <= er_d;
            plot_q    <= plot_d;
            vga_x_q   <= vga_x_d;
            vga_y_q   <= vga_y_d;
            vga_col_q <= vga_col_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_o;
    assign bus.busy       = busy_o;
    assign bus.rom_sym    = sym_q;
    assign bus.rom_dx     = dx_q;
    assign bus.rom_dy     = dy_q;
    assign bus.plot       = plot_q;
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_col_q;

endmodule

// File: tb/tb_symbol_draw_arbiter.sv
// tb/tb_symbol_draw_arbiter.sv - directed self-checking bench for symbol_draw_arbiter
module tb_symbol_draw_arbiter;
    import symbol_draw_arbiter_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    symbol_draw_arbiter_if #(.N_REQ(4), .SYM_W(16), .SYM_H(16)) bus ();

    symbol_draw_arbiter #(
        .N_REQ     (4),
        .SYM_W     (16),
        .SYM_H     (16),
        .BG_COLOUR (3'b000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int rom_mode = 0;
    assign bus.rom_bit = (rom_mode == 0) ? 1'b1 :
                         (rom_mode == 1) ? (bus.rom_dx == bus.rom_dy) : 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc, plot_cnt, grant_cnt, done_cnt, off_cnt, col_bad, diag_bad, range_bad;
    int last_done_cyc, x0, y0;
    logic [7:0] first_x, last_x;
    logic [6:0] first_y, last_y;
    logic [3:0] done_val, grant_watch, prev_grant;
    logic       done_with_plot;
    logic [2:0] exp_col;
    logic [3:0] gseq[$];
    int         gap[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample();
        cyc++;
        if (grant_watch != 4'b0 && bus.grant == grant_watch) grant_cnt++;
        if (bus.plot) begin
            if (plot_cnt == 0) begin
                first_x = bus.vga_x;
                first_y = bus.vga_y;
            end
            last_x = bus.vga_x;
            last_y = bus.vga_y;
            plot_cnt++;
            if (bus.vga_x > 8'd159 || bus.vga_y > 7'd119) off_cnt++;
            if (bus.vga_colour !== exp_col) col_bad++;
            if (int'(bus.vga_x) - x0 != int'(bus.vga_y) - y0) diag_bad++;
            if (int'(bus.vga_x) < x0 || int'(bus.vga_x) > x0 + 15 ||
                int'(bus.vga_y) < y0 || int'(bus.vga_y) > y0 + 15) range_bad++;
        end
        if (|bus.done) begin
            done_cnt++;
            done_val       = bus.done;
            done_with_plot = bus.plot;
            last_done_cyc  = cyc;
        end
        if (prev_grant == 4'b0 && bus.grant != 4'b0) begin
            gseq.push_back(bus.grant);
            gap.push_back(cyc - last_done_cyc);
        end
        prev_grant = bus.grant;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sample();
    endtask

    task automatic clear_stats();
        plot_cnt = 0; grant_cnt = 0; done_cnt = 0; off_cnt = 0;
        col_bad = 0; diag_bad = 0; range_bad = 0; last_done_cyc = 0;
        first_x = '0; first_y = '0; last_x = '0; last_y = '0;
        done_val = '0; done_with_plot = 1'b0; prev_grant = bus.grant;
        gseq.delete();
        gap.delete();
    endtask

    task automatic set_req(input int i, input int x, input int y, input int sym,
                           input int col, input int er);
        bus.req_x[8*i +: 8]      = x[7:0];
        bus.req_y[7*i +: 7]      = y[6:0];
        bus.req_sym[2*i +: 2]    = sym[1:0];
        bus.req_colour[3*i +: 3] = col[2:0];
        bus.erase[i]             = er[0];
    endtask

    task automatic run_to_done(input string tag, input int limit);
        int n;
        n = 0;
        while (done_cnt == 0 && n < limit) begin
            tick();
            n++;
        end
        check(tag, 32'(n < limit), 32'd1);
    endtask

    initial begin
        int n;
        cyc = 0;
        grant_watch = '0;
        exp_col = '0;
        x0 = 0;
        y0 = 0;
        bus.req = '0;
        bus.erase = '0;
        bus.req_x = '0;
        bus.req_y = '0;
        bus.req_sym = '0;
        bus.req_colour = '0;
        clear_stats();

        // Asynchronous reset before any clock edge
        #2 reset_n = 1'b0;
        #1;
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_done",  32'(bus.done),  32'd0);
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_plot",  32'(bus.plot),  32'd0);
        check("rst_vga",   {bus.vga_x, bus.vga_y, bus.vga_colour}, 32'd0);
        check("rst_rom",   {bus.rom_sym, bus.rom_dx, bus.rom_dy}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single full draw
        clear_stats();
        x0 = 10; y0 = 20; exp_col = 3'b011; grant_watch = 4'b0001; rom_mode = 0;
        set_req(0, 10, 20, 1, 3, 0);
        bus.req = 4'b0001;
        tick();
        check("t1_grant", 32'(bus.grant), 32'd1);
        check("t1_sym", 32'(bus.rom_sym), 32'd1);
        bus.req = 4'b0000;
        run_to_done("t1_timeout", 400);
        tick();
        tick();
        check("t1_grant_cycles", grant_cnt, 257);
        check("t1_plots", plot_cnt, 256);
        check("t1_first", {first_x, first_y}, {8'd10, 7'd20});
        check("t1_last", {last_x, last_y}, {8'd25, 7'd35});
        check("t1_colour", col_bad, 0);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_done_val", 32'(done_val), 32'd1);
        check("t1_done_with_plot", 32'(done_with_plot), 32'd1);
        check("t1_busy_after", 32'(bus.busy), 32'd0);

        // Mask gating on the diagonal
        clear_stats();
        x0 = 30; y0 = 40; exp_col = 3'b101; grant_watch = 4'b0001; rom_mode = 1;
        set_req(0, 30, 40, 2, 5, 0);
        bus.req = 4'b0001;
        tick();
        check("t2_grant", 32'(bus.grant), 32'd1);
        bus.req = 4'b0000;
        run_to_done("t2_timeout", 400);
        tick();
        check("t2_plots", plot_cnt, 16);
        check("t2_diag", diag_bad, 0);
        check("t2_first", {first_x, first_y}, {8'd30, 7'd40});
        check("t2_last", {last_x, last_y}, {8'd45, 7'd55});
        check("t2_colour", col_bad, 0);

        // Erase with clipping at the bottom-right corner
        clear_stats();
        x0 = 150; y0 = 110; exp_col = 3'b000; grant_watch = 4'b0010; rom_mode = 2;
        set_req(1, 150, 110, 3, 7, 1);
        bus.req = 4'b0010;
        tick();
        check("t3_grant", 32'(bus.grant), 32'd2);
        bus.req = 4'b0000;
        run_to_done("t3_timeout", 400);
        tick();
        check("t3_plots", plot_cnt, 100);
        check("t3_offscreen", off_cnt, 0);
        check("t3_colour", col_bad, 0);
        check("t3_range", range_bad, 0);
        check("t3_first", {first_x, first_y}, {8'd150, 7'd110});
        check("t3_last", {last_x, last_y}, {8'd159, 7'd119});
        check("t3_done_val", 32'(done_val), 32'd2);
        bus.erase = '0;

        // Round robin from reset with three requesters held
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        clear_stats();
        grant_watch = '0; rom_mode = 0;
        set_req(0, 0, 0, 0, 1, 0);
        set_req(1, 20, 0, 1, 2, 0);
        set_req(2, 40, 0, 2, 4, 0);
        bus.req = 4'b0111;
        n = 0;
        while (gseq.size() < 4 && n < 1200) begin
            tick();
            n++;
        end
        check("t4_timeout", 32'(gseq.size() >= 4), 32'd1);
        if (gseq.size() >= 4) begin
            check("t4_g0", 32'(gseq[0]), 32'd1);
            check("t4_g1", 32'(gseq[1]), 32'd2);
            check("t4_g2", 32'(gseq[2]), 32'd4);
            check("t4_g3", 32'(gseq[3]), 32'd1);
            check("t4_gap1", gap[1], 2);
            check("t4_gap2", gap[2], 2);
            check("t4_gap3", gap[3], 2);
        end
        bus.req = 4'b0000;
        n = 0;
        while (bus.busy && n < 400) begin
            tick();
            n++;
        end
        check("t4_idle", 32'(bus.busy), 32'd0);

        // Reset in the middle of a walk
        clear_stats();
        x0 = 10; y0 = 20; exp_col = 3'b011; grant_watch = 4'b0001; rom_mode = 0;
        set_req(0, 10, 20, 1, 3, 0);
        bus.req = 4'b0001;
        tick();
        bus.req = 4'b0000;
        n = 0;
        while (plot_cnt < 100 && n < 300) begin
            tick();
            n++;
        end
        check("t5_reached_100", plot_cnt, 100);
        reset_n = 1'b0;
        #1;
        check("t5_plot", 32'(bus.plot), 32'd0);
        check("t5_grant", 32'(bus.grant), 32'd0);
        check("t5_busy", 32'(bus.busy), 32'd0);
        tick();
        tick();
        check("t5_no_done", done_cnt, 0);
        set_req(1, 60, 60, 0, 6, 0);
        bus.req = 4'b0011;
        reset_n = 1'b1;
        tick();
        check("t5_first_grant", 32'(bus.grant), 32'd1);
        bus.req = 4'b0000;
        run_to_done("t5_timeout", 400);
        tick();

        // Latched data must survive input changes mid-walk
        clear_stats();
        x0 = 50; y0 = 60; exp_col = 3'b010; grant_watch = 4'b0001; rom_mode = 0;
        set_req(0, 50, 60, 0, 2, 0);
        bus.req = 4'b0001;
        tick();
        check("t6_grant", 32'(bus.grant), 32'd1);
        bus.req = 4'b0000;
        repeat (50) tick();
        set_req(0, 0, 0, 3, 7, 1);
        run_to_done("t6_timeout", 400);
        tick();
        check("t6_plots", plot_cnt, 256);
        check("t6_colour", col_bad, 0);
        check("t6_range", range_bad, 0);
        check("t6_last", {last_x, last_y}, {8'd65, 7'd75});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
